word_tokenizer: RTL

WORD_TOKENIZER -- requirements
Module: word_tokenizer

---
 rtl/word_tokenizer.sv | 107 ++++++++++
 1 files changed

// File: rtl/word_tokenizer.sv
// Word tokenizer: classifies space-delimited ASCII words as BEGIN, END or OTHER
// and reports each completed word with its saturating length and a running count.
module word_tokenizer #(
  parameter int unsigned LEN_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in,
  output logic             tok_valid,
  output logic [1:0]       tok_code,
  output logic [LEN_W-1:0] word_len,
  output logic [CNT_W-1:0] tok_cnt
);

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_B1   = 4'd1;
  localparam logic [3:0] S_B2   = 4'd2;
  localparam logic [3:0] S_B3   = 4'd3;
  localparam logic [3:0] S_B4   = 4'd4;
  localparam logic [3:0] S_B5   = 4'd5;
  localparam logic [3:0] S_E1   = 4'd6;
  localparam logic [3:0] S_E2   = 4'd7;
  localparam logic [3:0] S_E3   = 4'd8;
  localparam logic [3:0] S_OTH  = 4'd9;

  localparam logic [1:0] TOK_NONE  = 2'b00;
  localparam logic [1:0] TOK_BEGIN = 2'b01;
  localparam logic [1:0] TOK_END   = 2'b10;
  localparam logic [1:0] TOK_OTHER = 2'b11;

  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

  logic [3:0]       state, state_nxt;
  logic [LEN_W-1:0] len, len_nxt;
  logic             is_space, is_letter;
  logic [7:0]       lower;
  logic             emit;
  logic [1:0]       code;

  // Character classification; letters folded to lowercase, symbols never match a letter
  always_comb begin
    is_space  = (in == 8'h20);
    is_letter = ((in >= 8'h41) && (in <= 8'h5A)) || ((in >= 8'h61) && (in <= 8'h7A));
    lower     = is_letter ? (in | 8'h20) : 8'h00;
  end

  // Next-state, token emission and length counter update
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    code      = TOK_NONE;
    len_nxt   = len;
    if (is_space) begin
      state_nxt = S_IDLE;
      len_nxt   = '0;
      if (state != S_IDLE) begin
        emit = 1'b1;
        if (state == S_B5)      code = TOK_BEGIN;
        else if (state == S_E3) code = TOK_END;
        else                    code = TOK_OTHER;
      end
    end else begin
      if (state == S_IDLE)     len_nxt = LEN_W'(1);
      else if (len != LEN_MAX) len_nxt = len + LEN_W'(1);
      case (state)
        S_IDLE:  state_nxt = (lower == 8'h62) ? S_B1 : ((lower == 8'h65) ? S_E1 : S_OTH);
        S_B1:    state_nxt = (lower == 8'h65) ? S_B2 : S_OTH;
        S_B2:    state_nxt = (lower == 8'h67) ? S_B3 : S_OTH;
        S_B3:    state_nxt = (lower == 8'h69) ? S_B4 : S_OTH;
        S_B4:    state_nxt = (lower == 8'h6E) ? S_B5 : S_OTH;
        S_E1:    state_nxt = (lower == 8'h6E) ? S_E2 : S_OTH;
        S_E2:    state_nxt = (lower == 8'h64) ? S_E3 : S_OTH;
        default: state_nxt = S_OTH;
      endcase
    end
  end

  // State and length counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      len   <= '0;
    end else begin
      state <= state_nxt;
      len   <= len_nxt;
    end
  end

  // Registered token outputs; length and count hold between tokens
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tok_valid <= 1'b0;
      tok_code  <= TOK_NONE;
      word_len  <= '0;
      tok_cnt   <= '0;
    end else begin
      tok_valid <= emit;
      tok_code  <= code;
      if (emit) begin
        word_len <= len;
        tok_cnt  <= tok_cnt + CNT_W'(1);
      end
    end
  end

endmodule
